// File: rtl/uart_tx_port.sv
// uart_tx_port: byte FIFO in front of an 8N1 serializer.
// CPU pushes with uartWriteReq/uartWriteReady; txd idles high.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uartWriteReq,
  input  logic [7:0] uartWriteData,
  output logic       uartWriteReady,
  output logic       txd,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [NW-1:0] cnt_q, cnt_d;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_last;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign push      = uartWriteReq && !full;
  assign baud_last = (baud_q == BAUD_LAST);

  assign uartWriteReady = !full;
  assign txd            = txd_q;
  assign busy           = (state_q != S_IDLE) || !empty;

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= uartWriteData;
    end
  end

  // Pointer and occupancy bookkeeping; push blocked while full.
  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          txd_d   = shift_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            txd_d   = shift_q[1];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Control and line registers; reset drops any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: frame-timeline reference model checked every cycle
// against txd, busy and uartWriteReady.
module tb_uart_tx_port;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int FL = 10 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       txd;
  logic       busy;

  typedef struct {
    int         start;
    logic [7:0] b;
  } frame_t;

  frame_t fq[$];
  int cyc      = 0;
  int last_end = 0;
  int checks   = 0;
  int passes   = 0;
  int fails    = 0;
  int n_hs     = 0;

  uart_tx_port #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uartWriteReq  (req),
    .uartWriteData (data),
    .uartWriteReady(ready),
    .txd           (txd),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // bytes accepted but whose frame has not yet started after edge e
  function automatic int occ(int e);
    int n = 0;
    foreach (fq[i]) if (fq[i].start > e) n++;
    return n;
  endfunction

  function automatic logic exp_txd(int e);
    int k;
    foreach (fq[i]) begin
      if (e >= fq[i].start && e < fq[i].start + FL) begin
        k = (e - fq[i].start) / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fq[i].b[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int e);
    foreach (fq[i]) if (fq[i].start + FL > e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic obs,
                       input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(output logic acc);
    int s;
    acc = req && !reset && (occ(cyc) < D);
    @(posedge clk);
    cyc++;
    if (acc) begin
      s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      fq.push_back('{s, data});
      last_end = s + FL;
      n_hs++;
    end
    while (fq.size() > 0 && fq[0].start + FL <= cyc)
      void'(fq.pop_front());
    #1;
    check("txd", txd, exp_txd(cyc));
    check("busy", busy, exp_busy(cyc));
    check("ready", ready, occ(cyc) < D);
  endtask

  task automatic idle(input int n);
    logic acc;
    req = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int   i;
    data = b;
    req  = 1'b1;
    i    = 0;
    do begin
      step(acc);
      i++;
    end while (!acc && i < 200);
    if (i >= 200) check("send_timeout", acc, 1'b1);
  endtask

  task automatic do_reset();
    logic acc;
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    fq.delete();
    last_end = 0;
    step(acc);
    step(acc);
    #2 reset = 1'b0;
  endtask

  int n0;

  initial begin
    #1 reset = 1'b1;
    #1;
    check("por_txd", txd, 1'b1);
    check("por_busy", busy, 1'b0);
    check("por_ready", ready, 1'b1);
    idle(2);
    #2 reset = 1'b0;
    idle(100);

    send(8'hA5);
    idle(50);

    for (int b = 1; b <= 6; b++) send(8'(b));
    idle(260);

    send(8'h5A);
    n0 = cyc;
    send(8'h11);
    send(8'h22);
    idle(n0 + 1 + 17 - cyc);
    do_reset();
    idle(30);
    send(8'h3C);
    idle(50);

    for (int b = 0; b < 5; b++) send(8'(8'h40 + b));
    send(8'h77);
    idle(300);

    send(8'h00);
    send(8'hFF);
    idle(100);

    for (int j = 0; j < 30; j++) begin
      send(8'($urandom_range(0, 255)));
      idle($urandom_range(0, 50));
    end
    idle(400);

    check("final_idle", busy, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
